// File: rtl/mem_port_arbiter_if.sv
// Request, response and SRAM signals shared between the IFU/LSU requesters,
// the memory port arbiter and the unified single-port SRAM.
interface mem_port_arbiter_if;
  // Instruction fetch side
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_cancel;
  logic        ifu_gnt;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  // Load/store side
  logic        lsu_req;
  logic [3:0]  lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  // SRAM side
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // Status
  logic        busy;

  // Arbiter view: serves requests and owns the SRAM strobes
  modport slave (
    input  ifu_req, ifu_addr, ifu_cancel,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
    input  mem_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  // Requester/SRAM-model view
  modport master (
    output ifu_req, ifu_addr, ifu_cancel,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata,
    output mem_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-port SRAM between instruction fetch
// and load/store. One access at a time: grant (IDLE) -> one-cycle SRAM strobe
// (ISSUE) -> fixed read latency (WAIT) -> one-cycle rvalid to the owner.
// Loads/stores win over fetches until STARVE_MAX consecutive data grants have
// been given while a fetch waits; a fetch result can be dropped on redirect.
module mem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_starve_cnt;
  logic [2:0]  r_lat_cnt;
  logic        r_owner_ifu;
  logic        r_drop;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_we;
  logic        r_ifu_rvalid;
  logic [31:0] r_ifu_rdata;
  logic        r_lsu_rvalid;
  logic [31:0] r_lsu_rdata;

  logic        w_idle;
  logic        w_lsu_gnt;
  logic        w_ifu_gnt;
  logic        w_any_gnt;
  logic        w_done;
  logic        w_drop_now;
  logic        w_mem_en;
  logic [3:0]  w_mem_we;

  // Grants are only ever given from IDLE; data wins unless the fetch side has
  // already been passed over STARVE_MAX times in a row.
  assign w_idle     = (r_state == IDLE);
  assign w_lsu_gnt  = w_idle & bus.lsu_req & (~bus.ifu_req | (r_starve_cnt < STARVE_LIM));
  assign w_ifu_gnt  = w_idle & bus.ifu_req & ~w_lsu_gnt;
  assign w_any_gnt  = w_lsu_gnt | w_ifu_gnt;
  assign w_done     = (r_state == WAIT) && (r_lat_cnt == 3'd0);
  // A cancel in the last WAIT cycle must still suppress the result.
  assign w_drop_now = r_drop | bus.ifu_cancel;

  // State register
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and SRAM strobes; the strobe is asserted only in ISSUE
  always_comb begin
    w_state_next = r_state;
    w_mem_en     = 1'b0;
    w_mem_we     = 4'h0;
    case (r_state)
      IDLE: begin
        if (w_any_gnt) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_state_next = WAIT;
        w_mem_en     = 1'b1;
        w_mem_we     = r_we;
      end
      WAIT: begin
        if (r_lat_cnt == 3'd0) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Latch the winner's request; address/data then hold until the next grant
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_owner_ifu <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_we        <= 4'h0;
    end else if (w_any_gnt) begin
      r_owner_ifu <= w_ifu_gnt;
      r_addr      <= w_ifu_gnt ? bus.ifu_addr : bus.lsu_addr;
      r_wdata     <= w_ifu_gnt ? 32'h0 : bus.lsu_wdata;
      r_we        <= w_ifu_gnt ? 4'h0 : bus.lsu_we;
    end
  end

  // Read-latency counter: loaded while the SRAM is strobed, counts down in WAIT
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_lat_cnt <= 3'd0;
    end else if (r_state == ISSUE) begin
      r_lat_cnt <= LAT_LOAD;
    end else if ((r_state == WAIT) && (r_lat_cnt != 3'd0)) begin
      r_lat_cnt <= r_lat_cnt - 3'd1;
    end
  end

  // Drop flag: any cancel from the fetch grant through the last WAIT cycle
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_drop <= 1'b0;
    end else if (w_any_gnt) begin
      r_drop <= w_ifu_gnt & bus.ifu_cancel;
    end else if (!w_idle && r_owner_ifu && bus.ifu_cancel) begin
      r_drop <= 1'b1;
    end
  end

  // Return path: capture SRAM data for the owner and pulse its rvalid once
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_ifu_rvalid <= 1'b0;
      r_ifu_rdata  <= 32'h0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_rdata  <= 32'h0;
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      if (w_done) begin
        if (r_owner_ifu) begin
          if (!w_drop_now) begin
            r_ifu_rvalid <= 1'b1;
            r_ifu_rdata  <= bus.mem_rdata;
          end
        end else begin
          r_lsu_rvalid <= 1'b1;
          // Stores complete with a zero word; the SRAM read value is ignored
          r_lsu_rdata  <= (r_we == 4'h0) ? bus.mem_rdata : 32'h0;
        end
      end
    end
  end

  // Anti-starvation counter: counts data grants taken while a fetch waits
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_starve_cnt <= 4'd0;
    end else if (w_idle) begin
      if (w_ifu_gnt || !bus.ifu_req) begin
        r_starve_cnt <= 4'd0;
      end else if (w_lsu_gnt && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign bus.ifu_gnt    = w_ifu_gnt;
  assign bus.lsu_gnt    = w_lsu_gnt;
  assign bus.ifu_rvalid = r_ifu_rvalid;
  assign bus.ifu_rdata  = r_ifu_rdata;
  assign bus.lsu_rvalid = r_lsu_rvalid;
  assign bus.lsu_rdata  = r_lsu_rdata;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.busy       = ~w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: three instances (RD_LAT = 1, 3, 7) run the
// same directed + random traffic. Each has a requester driver, an SRAM model
// with the configured latency, and a cycle model that predicts grants and
// pushes each accepted access onto a scoreboard, popped when its rvalid is due.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lreq_t;

  typedef struct {
    bit          is_ifu;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          iss;
    int          rv;
    bit          drop;
  } txn_t;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // SRAM contents as seen by reads (reset vector holds a known instruction)
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h0280_0421;
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0F0F;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 7);

    mem_port_arbiter_if bus_if ();
    logic        rstn;
    logic [31:0] pipe [LAT];
    logic [31:0] iq [$];
    lreq_t       lq [$];
    txn_t        mq [$];
    int          m_free = 0;
    int          m_starve = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_irdata = 32'h0;
    logic [31:0] m_lrdata = 32'h0;
    bit          armed = 1'b0;
    bit          fin = 1'b0;

    mem_port_arbiter #(.RD_LAT(LAT), .STARVE_MAX(STARVE)) u_dut (
      .cpu_clk  (clk),
      .cpu_rstn (rstn),
      .bus      (bus_if)
    );

    // SRAM model: read data appears exactly LAT cycles after mem_en, junk otherwise
    always @(posedge clk) begin
      pipe[0] <= bus_if.mem_en ? mem_fn(bus_if.mem_addr) : $urandom;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus_if.mem_rdata = pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("lat%0d cyc%0d %s", LAT, cyc, nm), act, exp);
    endtask

    // Requester driver: present queue heads, hold them until granted
    initial begin : drv
      bus_if.ifu_req   = 1'b0;
      bus_if.ifu_addr  = 32'h0;
      bus_if.lsu_req   = 1'b0;
      bus_if.lsu_we    = 4'h0;
      bus_if.lsu_addr  = 32'h0;
      bus_if.lsu_wdata = 32'h0;
      forever begin
        @(posedge clk);
        #1;
        if (iq.size() > 0) begin
          bus_if.ifu_req  = 1'b1;
          bus_if.ifu_addr = iq[0];
        end else begin
          bus_if.ifu_req = 1'b0;
        end
        if (lq.size() > 0) begin
          bus_if.lsu_req   = 1'b1;
          bus_if.lsu_we    = lq[0].we;
          bus_if.lsu_addr  = lq[0].addr;
          bus_if.lsu_wdata = lq[0].wdata;
        end else begin
          bus_if.lsu_req = 1'b0;
        end
      end
    end

    // Cycle model + scoreboard, sampled mid-cycle
    initial begin : model
      int   c;
      bit   idle, e_lsu, e_ifu, e_en, e_irv, e_lrv;
      txn_t t;
      forever begin
        @(negedge clk);
        c = cyc;
        if (armed) begin
          idle  = (c >= m_free);
          e_lsu = idle && bus_if.lsu_req && (!bus_if.ifu_req || (m_starve < STARVE));
          e_ifu = idle && bus_if.ifu_req && !e_lsu;
          chk("ifu_gnt", 32'(bus_if.ifu_gnt), 32'(e_ifu));
          chk("lsu_gnt", 32'(bus_if.lsu_gnt), 32'(e_lsu));
          chk("busy", 32'(bus_if.busy), 32'(!idle));
          e_en = (mq.size() > 0) && (mq[0].iss == c);
          chk("mem_en", 32'(bus_if.mem_en), 32'(e_en));
          chk("mem_we", 32'(bus_if.mem_we), e_en ? 32'(mq[0].we) : 32'h0);
          if (e_en) m_addr = mq[0].addr;
          chk("mem_addr", bus_if.mem_addr, m_addr);
          if (e_en && !mq[0].is_ifu) chk("mem_wdata", bus_if.mem_wdata, mq[0].wdata);
          e_irv = 1'b0;
          e_lrv = 1'b0;
          if ((mq.size() > 0) && (mq[0].rv == c)) begin
            t = mq.pop_front();
            if (t.is_ifu) begin
              if (!t.drop) begin
                e_irv    = 1'b1;
                m_irdata = t.data;
              end
            end else begin
              e_lrv    = 1'b1;
              m_lrdata = (t.we == 4'h0) ? t.data : 32'h0;
            end
            $display("lat%0d cyc%0d %s addr=%h we=%h rdata=%h%s", LAT, c,
                     t.is_ifu ? "IFU" : "LSU", t.addr, t.we,
                     t.is_ifu ? m_irdata : m_lrdata, t.drop ? " dropped" : "");
          end
          chk("ifu_rvalid", 32'(bus_if.ifu_rvalid), 32'(e_irv));
          chk("lsu_rvalid", 32'(bus_if.lsu_rvalid), 32'(e_lrv));
          chk("ifu_rdata", bus_if.ifu_rdata, m_irdata);
          chk("lsu_rdata", bus_if.lsu_rdata, m_lrdata);
          if (e_lsu || e_ifu) begin
            t.is_ifu = e_ifu;
            t.we     = e_ifu ? 4'h0 : bus_if.lsu_we;
            t.addr   = e_ifu ? bus_if.ifu_addr : bus_if.lsu_addr;
            t.wdata  = bus_if.lsu_wdata;
            t.data   = mem_fn(t.addr);
            t.iss    = c + 1;
            t.rv     = c + 2 + LAT;
            t.drop   = 1'b0;
            mq.push_back(t);
            m_free   = c + 2 + LAT;
          end
          if ((mq.size() > 0) && mq[0].is_ifu && bus_if.ifu_cancel && (c < mq[0].rv))
            mq[0].drop = 1'b1;
          if (idle) begin
            if (e_ifu || !bus_if.ifu_req) m_starve = 0;
            else if (e_lsu && (m_starve < 15)) m_starve++;
          end
        end
        if (bus_if.ifu_gnt && (iq.size() > 0)) void'(iq.pop_front());
        if (bus_if.lsu_gnt && (lq.size() > 0)) void'(lq.pop_front());
        if (!rstn) begin
          mq.delete();
          m_free   = c + 1;
          m_starve = 0;
          m_addr   = 32'h0;
          m_irdata = 32'h0;
          m_lrdata = 32'h0;
          armed    = 1'b1;
        end
      end
    end

    task automatic wait_idle();
      bit tmo = 1'b1;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk);
        #2;
        if ((iq.size() == 0) && (lq.size() == 0) && (mq.size() == 0) && (cyc >= m_free)) begin
          tmo = 1'b0;
          break;
        end
      end
      chk("idle_timeout", 32'(tmo), 32'h0);
      if (tmo) begin
        iq.delete();
        lq.delete();
      end
    endtask

    // Wait (bounded) until the fetch queue has drained to 'left' entries
    task automatic wait_iq(input int left);
      bit tmo = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #2;
        if (iq.size() <= left) begin
          tmo = 1'b0;
          break;
        end
      end
      chk("ifu_gnt_timeout", 32'(tmo), 32'h0);
    endtask

    initial begin : stim
      bit tmo;
      rstn              = 1'b0;
      bus_if.ifu_cancel = 1'b0;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;

      // Reset-vector fetch
      iq.push_back(32'h1C00_0000);
      wait_idle();

      // Simultaneous fetch and loads: starvation limit forces the fetch in
      for (int i = 0; i < 6; i++) lq.push_back('{4'h0, 32'h100 + 32'(4 * i), 32'h0});
      iq.push_back(32'h1C00_0004);
      iq.push_back(32'h1C00_0008);
      wait_idle();

      // Stores (contiguous and non-contiguous strobes) and a load-back
      lq.push_back('{4'b0011, 32'h204, 32'h0000_BEEF});
      lq.push_back('{4'b1010, 32'h208, 32'h1234_5678});
      lq.push_back('{4'b0000, 32'h204, 32'h0});
      wait_idle();

      // Cancel in WAIT drops fetch A; fetch B is granted in A's return slot
      iq.push_back(32'h1C00_0010);
      iq.push_back(32'h1C00_0014);
      wait_iq(1);
      @(posedge clk);
      #2 bus_if.ifu_cancel = 1'b1;
      @(posedge clk);
      #2 bus_if.ifu_cancel = 1'b0;
      wait_idle();

      // Cancel in the rvalid cycle has no effect
      iq.push_back(32'h1C00_0018);
      wait_iq(0);
      repeat (LAT + 1) @(posedge clk);
      #2 bus_if.ifu_cancel = 1'b1;
      @(posedge clk);
      #2 bus_if.ifu_cancel = 1'b0;
      wait_idle();

      // Reset in WAIT abandons the load; a fresh fetch then completes
      lq.push_back('{4'h0, 32'h300, 32'h0});
      tmo = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #2;
        if (lq.size() == 0) begin
          tmo = 1'b0;
          break;
        end
      end
      chk("lsu_gnt_timeout", 32'(tmo), 32'h0);
      @(posedge clk);
      #2 rstn = 1'b0;
      @(posedge clk);
      #2 rstn = 1'b1;
      iq.push_back(32'h1C00_0020);
      wait_idle();

      // Back-to-back loads held on lsu_req
      for (int i = 0; i < 4; i++) lq.push_back('{4'h0, 32'h400 + 32'(4 * i), 32'h0});
      wait_idle();

      // Random mixed traffic
      for (int i = 0; i < 30; i++) begin
        case ($urandom_range(0, 3))
          0: iq.push_back(32'h1C00_1000 + 32'($urandom_range(0, 255) * 4));
          1: lq.push_back('{4'h0, 32'($urandom_range(0, 4095) * 4), 32'h0});
          2: lq.push_back('{4'($urandom_range(1, 15)), 32'($urandom_range(0, 4095) * 4), $urandom});
          default: begin
            iq.push_back(32'h1C00_2000 + 32'($urandom_range(0, 255) * 4));
            lq.push_back('{4'h0, 32'($urandom_range(0, 4095) * 4), 32'h0});
          end
        endcase
        repeat ($urandom_range(0, LAT + 3)) @(posedge clk);
      end
      wait_idle();
      fin = 1'b1;
    end
  end

  initial begin : finish_ctl
    bit all_fin = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (g_lat[0].fin && g_lat[1].fin && g_lat[2].fin) begin
        all_fin = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    check("global_timeout", 32'(all_fin), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified SRAM between instruction fetch (IFU) and the load/store path (LSU) of the pipelined LA32R core.
- Grants one requester at a time and drives the SRAM for one cycle.
- Waits a fixed read latency, then returns data or completion to the granted side.
- Data accesses have priority, bounded by an anti-starvation counter; in-flight fetches can be cancelled on branch redirect.

Parameters:
RD_LAT, 1, SRAM cycles from mem_en to valid mem_rdata; legal range 1..7
STARVE_MAX, 4, max consecutive LSU grants while ifu_req is pending before the IFU is forced in; legal range 1..15

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rstn  in  1  synchronous active-low reset
ifu_req  in  1  fetch request; held with ifu_addr until ifu_gnt
ifu_addr  in  32  fetch word address
ifu_cancel  in  1  drop the result of any accepted, not-yet-returned fetch
ifu_gnt  out  1  fetch accepted this cycle
ifu_rvalid  out  1  one-cycle pulse, ifu_rdata valid
ifu_rdata  out  32  fetched instruction
lsu_req  in  1  data request; held with lsu_we/addr/wdata until lsu_gnt
lsu_we  in  4  byte write strobes (store encoding from decode); 0 = load
lsu_addr  in  32  data address
lsu_wdata  in  32  store data, byte lanes pre-aligned
lsu_gnt  out  1  data request accepted this cycle
lsu_rvalid  out  1  one-cycle pulse: load data valid or store complete
lsu_rdata  out  32  raw load word (extension done downstream); 0 for stores
mem_en  out  1  SRAM access strobe
mem_we  out  4  SRAM byte write enables
mem_addr  out  32  SRAM address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data
busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset (cpu_rstn==0 at a rising edge):
  - All registered outputs go to 0 and the state goes to IDLE.
  - starve_cnt, lat_cnt and the owner/cancel flags clear.
  - An in-flight transaction is abandoned with no rvalid.
- States: IDLE, ISSUE, WAIT.
- Grant decision is combinational, IDLE only:
  - lsu_gnt = lsu_req & (!ifu_req | starve_cnt < STARVE_MAX).
  - ifu_gnt = ifu_req & !lsu_gnt.
  - Both grants are 0 outside IDLE. At most one grant per cycle.
- On a grant in cycle T:
  - The winner's address, we (0 for IFU), wdata and owner are latched.
  - State goes to ISSUE at T+1.
- ISSUE (cycle T+1):
  - mem_en=1 and mem_we/mem_addr/mem_wdata are driven from the latched registers.
  - lat_cnt loads RD_LAT-1 and the state goes to WAIT.
  - In all other cycles mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last value.
- WAIT: lat_cnt decrements each cycle. When lat_cnt==0 (cycle T+1+RD_LAT):
  - mem_rdata is registered into the owner's rdata, and the owner's rvalid is set for cycle T+2+RD_LAT.
  - State returns to IDLE.
- Throughput: a new grant is possible in the rvalid cycle, i.e. one access per RD_LAT+2 cycles.
- Stores: lsu_rvalid is still pulsed at T+2+RD_LAT with lsu_rdata=0, and the SRAM read value is ignored.
- starve_cnt:
  - +1 on each lsu_gnt while ifu_req=1, saturating at 15.
  - Clears on ifu_gnt or when ifu_req=0 in IDLE.
- Cancel:
  - ifu_cancel=1 in any cycle from the ifu_gnt cycle through the last WAIT cycle sets a drop flag.
  - The drop flag suppresses that fetch's ifu_rvalid; ifu_rdata is not updated. The SRAM access itself still completes.
  - ifu_cancel in the rvalid cycle or in IDLE has no effect on the current or a pending grant.
  - If ifu_cancel and ifu_req are high together in IDLE, the grant proceeds normally.
- Requests arriving while busy=1 are not granted. Requesters must hold their inputs stable until granted.
- Request inputs are sampled only in IDLE. lsu_we is passed through unmodified, including non-contiguous strobes.

Test Plan:
1. RD_LAT=1, IDLE, ifu_req=1, ifu_addr=0x1C000000, mem_rdata=0x02800421 returned -> ifu_gnt in cycle 0; mem_en=1 with mem_addr=0x1C000000 and mem_we=0 in cycle 1; ifu_rvalid=1 with ifu_rdata=0x02800421 in cycle 3.
2. Simultaneous ifu_req and lsu_req (load, lsu_addr=0x100) -> lsu_gnt first; LSU grants continue until STARVE_MAX=4 while ifu_req is held; the 5th grant goes to the IFU (ifu_gnt) and starve_cnt resets to 0.
3. Store: lsu_we=4'b0011, lsu_addr=0x204, lsu_wdata=0x0000BEEF -> mem_we=4'b0011, mem_addr=0x204, mem_wdata=0x0000BEEF for exactly one cycle; lsu_rvalid pulses with lsu_rdata=0; ifu_rvalid stays 0.
4. Fetch granted, then ifu_cancel=1 during WAIT (RD_LAT=3) -> no ifu_rvalid; busy drops at the normal time; the next ifu_req is granted in that cycle and returns normally.
5. Reset asserted in WAIT -> next cycle: busy=0, mem_en=0, no rvalid; a fresh request after release completes with correct latency.
6. RD_LAT=7, back-to-back loads held on lsu_req -> lsu_gnt every 9 cycles; each lsu_rdata matches the mem_rdata presented 7 cycles after its mem_en.
